// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared constants and types for the perf_mon_ctrl performance monitor.
// MMIO word offsets, CTRL/STATUS bit positions, dump length, counter index and
// dump FSM state encodings, plus the snapshot byte-select helper.
package perf_mon_pkg;

   localparam int unsigned DUMP_BYTES = 32;

   // MMIO word offsets, i.e. byte address bits [5:2]
   localparam logic [3:0] WORD_CTRL   = 4'd0;
   localparam logic [3:0] WORD_STATUS = 4'd1;
   localparam logic [3:0] WORD_CYC_LO = 4'd2;
   localparam logic [3:0] WORD_CYC_HI = 4'd3;
   localparam logic [3:0] WORD_INS_LO = 4'd4;
   localparam logic [3:0] WORD_INS_HI = 4'd5;
   localparam logic [3:0] WORD_BR_LO  = 4'd6;
   localparam logic [3:0] WORD_BR_HI  = 4'd7;
   localparam logic [3:0] WORD_MIS_LO = 4'd8;
   localparam logic [3:0] WORD_MIS_HI = 4'd9;

   // CTRL and STATUS bit positions
   localparam int unsigned CTRL_RUN  = 0;
   localparam int unsigned CTRL_CLR  = 1;
   localparam int unsigned CTRL_SNAP = 2;
   localparam int unsigned CTRL_DUMP = 3;
   localparam int unsigned STAT_RUN  = 0;
   localparam int unsigned STAT_BUSY = 1;

   typedef enum logic [1:0] {
      CNT_CYC = 2'd0,
      CNT_INS = 2'd1,
      CNT_BR  = 2'd2,
      CNT_MIS = 2'd3
   } cnt_idx_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } dump_state_e;

   // Byte idx of the flattened {MIS, INS... } image; byte 0 is CYC bits [7:0].
   function automatic logic [7:0] snap_byte(input logic [255:0] flat, input logic [4:0] idx);
      return flat[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/perf_mon_ctrl_if.sv
// perf_mon_ctrl_if: MMIO register window and byte-stream dump port of the
// performance monitor. master = CPU/sink side, slave = the monitor.
interface perf_mon_ctrl_if;
   logic        i_wr_en;
   logic        i_rd_en;
   logic [5:0]  i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_dump_vld;
   logic [7:0]  o_dump_data;
   logic        i_dump_rdy;
   logic        o_dump_done;

   modport master (
      output i_wr_en, i_rd_en, i_addr, i_wdata, i_dump_rdy,
      input  o_rdata, o_dump_vld, o_dump_data, o_dump_done
   );

   modport slave (
      input  i_wr_en, i_rd_en, i_addr, i_wdata, i_dump_rdy,
      output o_rdata, o_dump_vld, o_dump_data, o_dump_done
   );
endinterface

// File: rtl/perf_counter.sv
// perf_counter: free-running event counter with enable and clear; clear wins
// over a simultaneous event. Wraps modulo 2^CNT_W.
module perf_counter #(
   parameter int CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] cnt_r;

   // Count register: synchronous active-low reset, clear beats increment.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (i_clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (i_en) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign o_cnt = cnt_r;

endmodule

// File: rtl/perf_mon_ctrl.sv
// perf_mon_ctrl: performance-monitor controller. Four live counters (cycles,
// retired, control-flow, mispredicts), a coherent snapshot readable over MMIO,
// and an optional byte-stream dump of the snapshot.
// Build option: define PERF_DUMP_EN to include the dump FSM and port; without
// it the dump outputs are tied low and the CTRL DUMP bit is ignored.
module perf_mon_ctrl
   import perf_mon_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_insn_vld,
   input  logic            i_ctrl,
   input  logic            i_mispred,
   perf_mon_ctrl_if.slave  bus
);

   logic [3:0]       word_s;
   logic             wr_ctrl_s;
   logic             clr_s;
   logic             snap_req_s;
   logic             dump_req_s;
   logic             dump_busy_s;
   logic             run_r;
   logic [3:0]       ev_s;
   logic [CNT_W-1:0] live_s [4];
   logic [CNT_W-1:0] snap_r [4];
   logic [31:0]      rd_val_s;
   logic [31:0]      rdata_r;
   logic             unused_s;

   assign word_s     = bus.i_addr[5:2];
   assign wr_ctrl_s  = bus.i_wr_en && (word_s == WORD_CTRL);
   assign clr_s      = wr_ctrl_s && bus.i_wdata[CTRL_CLR];
   // A snapshot must stay frozen while it is being streamed out.
   assign snap_req_s = (wr_ctrl_s && bus.i_wdata[CTRL_SNAP] && !dump_busy_s) || dump_req_s;
   assign ev_s       = {i_mispred, i_ctrl, i_insn_vld, 1'b1};

   // RUN bit: updated by any CTRL write, also during a dump.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         run_r <= 1'b0;
      end else if (wr_ctrl_s) begin
         run_r <= bus.i_wdata[CTRL_RUN];
      end else begin
         run_r <= run_r;
      end
   end

   perf_counter #(.CNT_W(CNT_W)) u_cyc (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(run_r & ev_s[CNT_CYC]),
      .i_clr(clr_s), .o_cnt(live_s[CNT_CYC]));
   perf_counter #(.CNT_W(CNT_W)) u_ins (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(run_r & ev_s[CNT_INS]),
      .i_clr(clr_s), .o_cnt(live_s[CNT_INS]));
   perf_counter #(.CNT_W(CNT_W)) u_br (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(run_r & ev_s[CNT_BR]),
      .i_clr(clr_s), .o_cnt(live_s[CNT_BR]));
   perf_counter #(.CNT_W(CNT_W)) u_mis (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(run_r & ev_s[CNT_MIS]),
      .i_clr(clr_s), .o_cnt(live_s[CNT_MIS]));

   // Snapshot capture: all four counters in one edge, pre-increment/pre-clear values.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int i = 0; i < 4; i++) snap_r[i] <= {CNT_W{1'b0}};
      end else if (snap_req_s) begin
         for (int i = 0; i < 4; i++) snap_r[i] <= live_s[i];
      end else begin
         for (int i = 0; i < 4; i++) snap_r[i] <= snap_r[i];
      end
   end

   // Read mux: counter words always come from the snapshot, unmapped words read 0.
   always_comb begin
      rd_val_s = 32'h0000_0000;
      case (word_s)
         WORD_CTRL:   rd_val_s[CTRL_RUN] = run_r;
         WORD_STATUS: begin
            rd_val_s[STAT_RUN]  = run_r;
            rd_val_s[STAT_BUSY] = dump_busy_s;
         end
         WORD_CYC_LO: rd_val_s = snap_r[CNT_CYC][31:0];
         WORD_CYC_HI: rd_val_s = snap_r[CNT_CYC][63:32];
         WORD_INS_LO: rd_val_s = snap_r[CNT_INS][31:0];
         WORD_INS_HI: rd_val_s = snap_r[CNT_INS][63:32];
         WORD_BR_LO:  rd_val_s = snap_r[CNT_BR][31:0];
         WORD_BR_HI:  rd_val_s = snap_r[CNT_BR][63:32];
         WORD_MIS_LO: rd_val_s = snap_r[CNT_MIS][31:0];
         WORD_MIS_HI: rd_val_s = snap_r[CNT_MIS][63:32];
         default:     rd_val_s = 32'h0000_0000;
      endcase
   end

   // Read data register: loads only on a read strobe, otherwise holds.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         rdata_r <= 32'h0000_0000;
      end else if (bus.i_rd_en) begin
         rdata_r <= rd_val_s;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign bus.o_rdata = rdata_r;

`ifdef PERF_DUMP_EN
   dump_state_e        state_r;
   logic [4:0]         idx_r;
   logic               dump_vld_r;
   logic [7:0]         dump_data_r;
   logic               dump_done_r;
   logic [4*CNT_W-1:0] live_flat_s;
   logic [4*CNT_W-1:0] snap_flat_s;

   assign live_flat_s = {live_s[3], live_s[2], live_s[1], live_s[0]};
   assign snap_flat_s = {snap_r[3], snap_r[2], snap_r[1], snap_r[0]};
   assign dump_busy_s = (state_r == ST_SEND);
   assign dump_req_s  = wr_ctrl_s && bus.i_wdata[CTRL_DUMP] && !dump_busy_s;

   // Dump sequencer: byte 0 is taken from the live values being captured this edge.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_r     <= ST_IDLE;
         idx_r       <= 5'd0;
         dump_vld_r  <= 1'b0;
         dump_data_r <= 8'h00;
         dump_done_r <= 1'b0;
      end else begin
         dump_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (dump_req_s) begin
                  state_r     <= ST_SEND;
                  idx_r       <= 5'd0;
                  dump_vld_r  <= 1'b1;
                  dump_data_r <= snap_byte(live_flat_s, 5'd0);
               end else begin
                  state_r     <= ST_IDLE;
                  dump_vld_r  <= 1'b0;
                  dump_data_r <= 8'h00;
               end
            end
            ST_SEND: begin
               if (bus.i_dump_rdy) begin
                  if (idx_r == 5'(DUMP_BYTES - 1)) begin
                     state_r     <= ST_IDLE;
                     idx_r       <= 5'd0;
                     dump_vld_r  <= 1'b0;
                     dump_data_r <= 8'h00;
                     dump_done_r <= 1'b1;
                  end else begin
                     idx_r       <= idx_r + 5'd1;
                     dump_data_r <= snap_byte(snap_flat_s, idx_r + 5'd1);
                  end
               end else begin
                  idx_r       <= idx_r;
                  dump_data_r <= dump_data_r;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               idx_r       <= 5'd0;
               dump_vld_r  <= 1'b0;
               dump_data_r <= 8'h00;
            end
         endcase
      end
   end

   assign bus.o_dump_vld  = dump_vld_r;
   assign bus.o_dump_data = dump_data_r;
   assign bus.o_dump_done = dump_done_r;
   assign unused_s        = ^{bus.i_wdata[31:4], bus.i_addr[1:0]};
`else
   assign dump_busy_s     = 1'b0;
   assign dump_req_s      = 1'b0;
   assign bus.o_dump_vld  = 1'b0;
   assign bus.o_dump_data = 8'h00;
   assign bus.o_dump_done = 1'b0;
   assign unused_s        = ^{bus.i_wdata[31:3], bus.i_addr[1:0], bus.i_dump_rdy};
`endif

endmodule

// File: tb/tb_perf_mon_ctrl.sv
// tb_perf_mon_ctrl: directed + randomized bench for perf_mon_ctrl against a
// behavioural model of counters, snapshot, MMIO reads and the dump stream.
module tb_perf_mon_ctrl;

`ifdef PERF_DUMP_EN
   localparam bit DUMP_EN = 1'b1;
`else
   localparam bit DUMP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic insn, ctrl, mis;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt;

   // reference model state
   logic [63:0] live_m [4];
   logic [63:0] snap_m [4];
   bit          run_m, busy_m, done_m;
   int          sent_m;
   logic [31:0] rdata_m;

   perf_mon_ctrl_if bus ();

   perf_mon_ctrl dut (
      .i_clk(clk), .i_reset(rst_n), .i_insn_vld(insn), .i_ctrl(ctrl),
      .i_mispred(mis), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mmio(input logic [3:0] w);
      logic [63:0] v;
      if (w == 4'd0) return {31'd0, run_m};
      if (w == 4'd1) return {30'd0, busy_m, run_m};
      if (w >= 4'd2 && w <= 4'd9) begin
         v = snap_m[int'(w - 4'd2) / 2];
         return (w[0] == 1'b1) ? v[63:32] : v[31:0];
      end
      return 32'd0;
   endfunction

   function automatic logic [7:0] exp_byte(input int k);
      return 8'(snap_m[k / 8] >> (8 * (k % 8)));
   endfunction

   // one clock edge of the reference behaviour, from the currently driven inputs
   function automatic void model_edge();
      logic [3:0] w;
      bit wrc, dstart, snap, clr;
      bit ev [4];
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin live_m[i] = 64'd0; snap_m[i] = 64'd0; end
         run_m = 1'b0; busy_m = 1'b0; done_m = 1'b0; sent_m = 0; rdata_m = 32'd0;
         return;
      end
      w   = bus.i_addr[5:2];
      wrc = bus.i_wr_en && (w == 4'd0);
      if (bus.i_rd_en) rdata_m = mmio(w);
      dstart = DUMP_EN && wrc && bus.i_wdata[3] && !busy_m;
      snap   = wrc && (bus.i_wdata[2] || dstart) && !busy_m;
      done_m = 1'b0;
      if (busy_m && bus.i_dump_rdy) begin
         sent_m++;
         if (sent_m == 32) begin busy_m = 1'b0; done_m = 1'b1; end
      end
      if (dstart) begin busy_m = 1'b1; sent_m = 0; end
      if (snap) for (int i = 0; i < 4; i++) snap_m[i] = live_m[i];
      clr = wrc && bus.i_wdata[1];
      ev  = '{1'b1, insn, ctrl, mis};
      for (int i = 0; i < 4; i++) begin
         if (clr) live_m[i] = 64'd0;
         else if (run_m && ev[i]) live_m[i] = live_m[i] + 64'd1;
      end
      if (wrc) run_m = bus.i_wdata[0];
   endfunction

   // advance one cycle (called at a negedge), then check every output
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("dump_vld",  {31'd0, bus.o_dump_vld},  {31'd0, busy_m});
      chk("dump_data", {24'd0, bus.o_dump_data}, {24'd0, busy_m ? exp_byte(sent_m) : 8'h00});
      chk("dump_done", {31'd0, bus.o_dump_done}, {31'd0, done_m});
      chk("rdata",     bus.o_rdata,              rdata_m);
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      bus.i_wr_en = 1'b1; bus.i_addr = a; bus.i_wdata = d;
      tick();
      bus.i_wr_en = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a);
      bus.i_rd_en = 1'b1; bus.i_addr = a;
      tick();
      bus.i_rd_en = 1'b0;
   endtask

   task automatic no_ev();
      insn = 1'b0; ctrl = 1'b0; mis = 1'b0;
   endtask

   task automatic rand_ev();
      insn = 1'($urandom_range(0, 1));
      ctrl = 1'($urandom_range(0, 1));
      mis  = ctrl & 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      bus.i_dump_rdy = 1'b1;
      for (int n = 0; n < 80 && busy_m; n++) tick();
   endtask

   initial begin
      logic [10:0] m11;
      logic [11:0] cm, mm;
      rst_n = 1'b0; no_ev();
      bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_addr = 6'd0;
      bus.i_wdata = 32'd0; bus.i_dump_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin live_m[i] = 64'd0; snap_m[i] = 64'd0; end
      run_m = 1'b0; busy_m = 1'b0; done_m = 1'b0; sent_m = 0; rdata_m = 32'd0;
      @(negedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      for (int a = 0; a < 64; a += 4) begin
         rd(6'(a));
         chk("reset_read", bus.o_rdata, 32'd0);
      end

      // 11 running cycles, 6 of them with a retired instruction
      wr(6'h00, 32'h1);
      do m11 = 11'($urandom); while ($countones(m11) != 6);
      for (int i = 0; i < 11; i++) begin insn = m11[i]; tick(); end
      no_ev();
      wr(6'h00, 32'h5);
      rd(6'h08); chk("cyc_lo", bus.o_rdata, 32'h0000_000B);
      rd(6'h0C); chk("cyc_hi", bus.o_rdata, 32'h0);
      rd(6'h10); chk("ins_lo", bus.o_rdata, 32'h6);
      rd(6'h14); chk("ins_hi", bus.o_rdata, 32'h0);

      // 5 control-flow, 2 mispredicted
      wr(6'h00, 32'h3);
      do cm = 12'($urandom); while ($countones(cm) != 5);
      do mm = 12'($urandom) & cm; while ($countones(mm) != 2);
      for (int i = 0; i < 12; i++) begin ctrl = cm[i]; mis = mm[i]; tick(); end
      no_ev();
      wr(6'h00, 32'h5);
      rd(6'h18); chk("br_lo", bus.o_rdata, 32'h5);
      rd(6'h20); chk("mis_lo", bus.o_rdata, 32'h2);

      // clear in the same cycle as events: clear wins
      insn = 1'b1; ctrl = 1'b1; mis = 1'b1;
      wr(6'h00, 32'h2);
      no_ev();
      wr(6'h00, 32'h4);
      for (int a = 8; a < 40; a += 8) begin
         rd(6'(a));
         chk("after_clr", bus.o_rdata, 32'h0);
      end

      // 32-bit carry of the cycle counter
      force dut.u_cyc.cnt_r = 64'h0000_0000_FFFF_FFF8;
      live_m[0] = 64'h0000_0000_FFFF_FFF8;
      tick();
      release dut.u_cyc.cnt_r;
      wr(6'h00, 32'h1);
      repeat (10) tick();
      wr(6'h00, 32'h4);
      rd(6'h08); chk("wrap_lo", bus.o_rdata, 32'h2);
      rd(6'h0C); chk("wrap_hi", bus.o_rdata, 32'h1);

      // randomized traffic
      for (int i = 0; i < 120; i++) begin
         rand_ev();
         bus.i_dump_rdy = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       wr(6'h00, $urandom);
            1:       wr(6'($urandom_range(0, 63)), $urandom);
            2:       rd(6'($urandom_range(0, 63)));
            default: tick();
         endcase
      end
      no_ev();
      drain();

`ifdef PERF_DUMP_EN
      // dump with a stalling sink, SNAP/CLR and a STATUS read while busy
      wr(6'h00, 32'h1);
      for (int i = 0; i < 8; i++) begin rand_ev(); tick(); end
      no_ev();
      wr(6'h00, 32'h9);
      done_cnt = 0;
      for (int n = 0; n < 80; n++) begin
         rand_ev();
         bus.i_dump_rdy = (n % 2 == 0);
         if (n == 3) begin bus.i_wr_en = 1'b1; bus.i_addr = 6'h00; bus.i_wdata = 32'h5; end
         if (n == 5) begin bus.i_rd_en = 1'b1; bus.i_addr = 6'h04; end
         if (n == 7) begin bus.i_wr_en = 1'b1; bus.i_addr = 6'h00; bus.i_wdata = 32'h3; end
         tick();
         bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;
         if (n == 5) chk("status_busy", bus.o_rdata, 32'h3);
         if (bus.o_dump_done) done_cnt++;
      end
      no_ev();
      chk("done_pulses", 32'(done_cnt), 32'd1);

      // reset while byte 10 is on the port
      bus.i_dump_rdy = 1'b1;
      wr(6'h00, 32'h9);
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      chk("vld_after_reset", {31'd0, bus.o_dump_vld}, 32'd0);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (bus.o_dump_done) done_cnt++;
      end
      chk("no_done_after_reset", 32'(done_cnt), 32'd0);
`else
      // DUMP bit has no effect without the dump build option
      wr(6'h00, 32'h1);
      for (int i = 0; i < 8; i++) begin rand_ev(); tick(); end
      no_ev();
      wr(6'h00, 32'h4);
      wr(6'h00, 32'h9);
      repeat (4) tick();
      rd(6'h04); chk("status_nodump", bus.o_rdata, 32'h1);
      rd(6'h08); chk("cyc_nodump", bus.o_rdata, snap_m[0][31:0]);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
`endif
      for (int a = 0; a < 40; a += 4) begin
         rd(6'(a));
         chk("post_reset_read", bus.o_rdata, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
